// File: rtl/hpi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hpi_pkg : shared types and HPI register selects for the HPI sequencer. rev 1.0
// ----------------------------------------------------------------------------
package hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_CHIPRST = 3'd4
  } hpi_state_t;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/hpi_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hpi_rr_arbiter : 2-way round-robin arbiter, one-hot grant. rev 1.0
// ----------------------------------------------------------------------------
module hpi_rr_arbiter (
  input  logic       enable,
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11)
        grant = last_grant ? 2'b01 : 2'b10;
      else
        grant = req;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hpi_access_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hpi_access_sequencer : arbitrates two requesters onto the OTG HPI bus and
// sequences read/write strobes and chip reset pulses. rev 1.0
// ----------------------------------------------------------------------------
module hpi_access_sequencer
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 6,
  parameter int HOLD_CYC   = 2,
  parameter int RESET_CYC  = 16,
  parameter int CNT_W      = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  input  logic        chip_rst_req,
  output logic [1:0]  hpi_addr,
  output logic        hpi_cs_n,
  output logic        hpi_r_n,
  output logic        hpi_w_n,
  output logic        hpi_rst_n,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  input  logic [15:0] hpi_data_in,
  output logic        busy
);

  hpi_state_t         state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               lat_we, lat_we_d;
  logic               lat_port, lat_port_d;
  logic [15:0]        rd_cap, rd_cap_d;
  logic               last_grant, last_grant_d;
  logic               rst_pending, rst_pending_d;

  logic [1:0]         addr_d;
  logic               cs_n_d, r_n_d, w_n_d, rst_n_d, oe_d, busy_d;
  logic [15:0]        dout_d;
  logic               ack0_d, ack1_d;
  logic [15:0]        rdata0_d, rdata1_d;

  logic [1:0]         elig, grant;
  logic               arb_en;
  logic               sel_we;
  logic [1:0]         sel_addr;
  logic [15:0]        sel_wdata;
  logic               cnt_last;

  // A port still showing its ack has just been served and must not be re-granted.
  assign elig     = {m1_req & ~m1_ack, m0_req & ~m0_ack};
  assign arb_en   = (state == ST_IDLE) && !rst_pending && !chip_rst_req;
  assign cnt_last = (cnt == CNT_W'(1));

  hpi_rr_arbiter u_arb (
    .enable     (arb_en),
    .req        (elig),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign sel_we    = grant[1] ? m1_we    : m0_we;
  assign sel_addr  = grant[1] ? m1_addr  : m0_addr;
  assign sel_wdata = grant[1] ? m1_wdata : m0_wdata;

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    lat_we_d      = lat_we;
    lat_port_d    = lat_port;
    rd_cap_d      = rd_cap;
    last_grant_d  = last_grant;
    rst_pending_d = rst_pending;
    addr_d        = hpi_addr;
    cs_n_d        = hpi_cs_n;
    r_n_d         = hpi_r_n;
    w_n_d         = hpi_w_n;
    rst_n_d       = hpi_rst_n;
    dout_d        = hpi_data_out;
    oe_d          = hpi_data_oe;
    busy_d        = busy;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    rdata0_d      = m0_rdata;
    rdata1_d      = m1_rdata;

    // Reset requests arriving mid-transaction are deferred until it completes.
    if (chip_rst_req && (state == ST_SETUP || state == ST_STROBE || state == ST_HOLD))
      rst_pending_d = 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (rst_pending || chip_rst_req) begin
          state_d       = ST_CHIPRST;
          cnt_d         = CNT_W'(RESET_CYC);
          rst_n_d       = 1'b0;
          busy_d        = 1'b1;
          rst_pending_d = 1'b0;
        end else if (grant != 2'b00) begin
          state_d      = ST_SETUP;
          cnt_d        = CNT_W'(SETUP_CYC);
          lat_we_d     = sel_we;
          lat_port_d   = grant[1];
          last_grant_d = grant[1];
          addr_d       = sel_addr;
          cs_n_d       = 1'b0;
          busy_d       = 1'b1;
          if (sel_we) begin
            oe_d   = 1'b1;
            dout_d = sel_wdata;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_last) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_W'(STROBE_CYC);
          if (lat_we) w_n_d = 1'b0;
          else        r_n_d = 1'b0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_last) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC);
          r_n_d   = 1'b1;
          w_n_d   = 1'b1;
          if (!lat_we) rd_cap_d = hpi_data_in;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_last) begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
          if (lat_port) begin
            ack1_d = 1'b1;
            if (!lat_we) rdata1_d = rd_cap;
          end else begin
            ack0_d = 1'b1;
            if (!lat_we) rdata0_d = rd_cap;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_CHIPRST: begin
        if (cnt_last) begin
          state_d = ST_IDLE;
          rst_n_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_CHIPRST;
        cnt_d   = CNT_W'(RESET_CYC);
        rst_n_d = 1'b0;
        cs_n_d  = 1'b1;
        r_n_d   = 1'b1;
        w_n_d   = 1'b1;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= ST_CHIPRST;
      cnt          <= CNT_W'(RESET_CYC);
      lat_we       <= 1'b0;
      lat_port     <= 1'b0;
      rd_cap       <= 16'h0000;
      last_grant   <= 1'b1;
      rst_pending  <= 1'b0;
      hpi_addr     <= 2'b00;
      hpi_cs_n     <= 1'b1;
      hpi_r_n      <= 1'b1;
      hpi_w_n      <= 1'b1;
      hpi_rst_n    <= 1'b0;
      hpi_data_out <= 16'h0000;
      hpi_data_oe  <= 1'b0;
      busy         <= 1'b1;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rdata     <= 16'h0000;
      m1_rdata     <= 16'h0000;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      lat_we       <= lat_we_d;
      lat_port     <= lat_port_d;
      rd_cap       <= rd_cap_d;
      last_grant   <= last_grant_d;
      rst_pending  <= rst_pending_d;
      hpi_addr     <= addr_d;
      hpi_cs_n     <= cs_n_d;
      hpi_r_n      <= r_n_d;
      hpi_w_n      <= w_n_d;
      hpi_rst_n    <= rst_n_d;
      hpi_data_out <= dout_d;
      hpi_data_oe  <= oe_d;
      busy         <= busy_d;
      m0_ack       <= ack0_d;
      m1_ack       <= ack1_d;
      m0_rdata     <= rdata0_d;
      m1_rdata     <= rdata1_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hpi_access_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hpi_access_sequencer : self-checking bench for hpi_access_sequencer. rev 1.0
// ----------------------------------------------------------------------------
module tb_hpi_access_sequencer;
  import hpi_pkg::*;

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdval;
    int          exp_lat;
  } txn_t;

  logic        clk_clk, reset_reset_n;
  logic        m0_req, m0_we, m1_req, m1_we, chip_rst_req;
  logic [1:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n, hpi_r_n, hpi_w_n, hpi_rst_n, hpi_data_oe, busy;
  logic [15:0] hpi_data_out, hpi_data_in, rd_value;

  int checks = 0;
  int errors = 0;
  txn_t sb[$];
  logic [15:0] last_rd [2];
  int cs_cnt, w_cnt, r_cnt, setup_cnt, field_err;
  txn_t mon_e;

  // The pad only carries the target's value while the read strobe is low.
  assign hpi_data_in = hpi_r_n ? 16'hDEAD : rd_value;

  hpi_access_sequencer dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .chip_rst_req(chip_rst_req),
    .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n),
    .hpi_rst_n(hpi_rst_n), .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe),
    .hpi_data_in(hpi_data_in), .busy(busy)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Bus monitor: measures each cs_n window and scores it at the ack.
  always @(negedge clk_clk) begin
    if (!reset_reset_n) begin
      cs_cnt = 0; w_cnt = 0; r_cnt = 0; setup_cnt = 0; field_err = 0;
    end else begin
      if (m0_ack || m1_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_both", {31'd0, m0_ack & m1_ack}, 0);
          chk("ack_port", {31'd0, m1_ack}, {31'd0, mon_e.port});
          chk("cs_low_cycles", cs_cnt, 10);
          chk("setup_cycles", setup_cnt, 2);
          chk("strobe_cycles", mon_e.we ? w_cnt : r_cnt, 6);
          chk("wrong_strobe", mon_e.we ? r_cnt : w_cnt, 0);
          chk("bus_fields", field_err, 0);
          chk("cs_gap_at_ack", {31'd0, hpi_cs_n}, 1);
          if (!mon_e.we) last_rd[mon_e.port] = mon_e.rdval;
          chk("m0_rdata", {16'd0, m0_rdata}, {16'd0, last_rd[0]});
          chk("m1_rdata", {16'd0, m1_rdata}, {16'd0, last_rd[1]});
        end
        cs_cnt = 0; w_cnt = 0; r_cnt = 0; setup_cnt = 0; field_err = 0;
      end
      if (!hpi_cs_n) begin
        cs_cnt++;
        if (!hpi_w_n) w_cnt++;
        if (!hpi_r_n) r_cnt++;
        if (hpi_w_n && hpi_r_n && w_cnt == 0 && r_cnt == 0) setup_cnt++;
        if (sb.size() > 0) begin
          if (hpi_addr !== sb[0].addr) field_err++;
          if (hpi_data_oe !== sb[0].we) field_err++;
          if (sb[0].we && hpi_data_out !== sb[0].wdata) field_err++;
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_clk); #1;
      if (!busy) return;
    end
    chk("timeout_idle", 1, 0);
  endtask

  task automatic drive(input txn_t e);
    rd_value = e.rdval;
    if (e.port) begin
      m1_we = e.we; m1_addr = e.addr; m1_wdata = e.wdata; m1_req = 1'b1;
    end else begin
      m0_we = e.we; m0_addr = e.addr; m0_wdata = e.wdata; m0_req = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic do_txn(input txn_t e, input int rst_at);
    int n;
    logic got;
    wait_idle();
    drive(e);
    got = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk_clk); #1;
      chip_rst_req = (n == rst_at);
      if (n == rst_at) chk("rst_in_strobe", {31'd0, e.we ? hpi_w_n : hpi_r_n}, 0);
      if (e.port ? m1_ack : m0_ack) begin got = 1'b1; break; end
    end
    chip_rst_req = 1'b0;
    chk("ack_latency", got ? n : 0, e.exp_lat);
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic powerup_check();
    int n;
    int cs_seen;
    logic prev_busy;
    cs_seen = 0; prev_busy = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk_clk); #1;
      if (!hpi_cs_n) cs_seen++;
      if (hpi_rst_n) break;
      prev_busy = busy;
    end
    chk("rst_pulse_len", n, 16);
    chk("busy_before_rel", {31'd0, prev_busy}, 1);
    chk("busy_fall", {31'd0, busy}, 0);
    chk("cs_during_rst", cs_seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t vec [6];
    int a0, a1, n;
    logic got;
    vec[0] = '{1'b0, 1'b1, HPI_ADDR,    16'h1234, 16'h0000, 11};
    vec[1] = '{1'b1, 1'b0, HPI_STATUS,  16'h0000, 16'hBEEF, 11};
    vec[2] = '{1'b0, 1'b0, HPI_DATA,    16'h0000, 16'hA5A5, 11};
    vec[3] = '{1'b1, 1'b1, HPI_MAILBOX, 16'hFFFF, 16'h0000, 11};
    vec[4] = '{1'b0, 1'b1, HPI_STATUS,  16'h0000, 16'h0000, 11};
    vec[5] = '{1'b1, 1'b0, HPI_ADDR,    16'h0000, 16'h0001, 11};

    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    reset_reset_n = 1'b0; chip_rst_req = 1'b0; rd_value = 16'h0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 2'd0; m0_wdata = 16'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 2'd0; m1_wdata = 16'h0;
    repeat (3) @(negedge clk_clk);
    chk("rst_hpi_rst_n", {31'd0, hpi_rst_n}, 0);
    chk("rst_strobes", {29'd0, hpi_cs_n, hpi_r_n, hpi_w_n}, 7);
    chk("rst_busy", {31'd0, busy}, 1);
    chk("rst_oe_acks", {29'd0, hpi_data_oe, m0_ack, m1_ack}, 0);
    chk("rst_addr_data", {14'd0, hpi_addr, hpi_data_out}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    reset_reset_n = 1'b1;
    powerup_check();

    for (int i = 0; i < 6; i++) do_txn(vec[i], 0);

    // Both ports request continuously: grants must alternate, starting with m0.
    wait_idle();
    rd_value = 16'h5AA5;
    for (int k = 0; k < 4; k++)
      sb.push_back('{k[0], ~k[0], HPI_MAILBOX, k[0] ? 16'h0000 : 16'hC0DE, 16'h5AA5, 11});
    m0_we = 1'b1; m0_addr = HPI_MAILBOX; m0_wdata = 16'hC0DE; m0_req = 1'b1;
    m1_we = 1'b0; m1_addr = HPI_MAILBOX; m1_wdata = 16'h0000; m1_req = 1'b1;
    a0 = 0; a1 = 0;
    for (int c = 0; c < 100 && (a0 < 2 || a1 < 2); c++) begin
      @(posedge clk_clk); #1;
      if (m0_ack) a0++;
      if (m1_ack) a1++;
      if (a0 >= 2) m0_req = 1'b0;
      if (a1 >= 2) m1_req = 1'b0;
    end
    chk("contention_acks", a0 + a1, 4);
    m0_req = 1'b0; m1_req = 1'b0;

    // Chip reset requested in the 3rd strobe cycle: write completes, then reset.
    do_txn('{1'b0, 1'b1, HPI_DATA, 16'h3C3C, 16'h0000, 11}, 5);
    @(posedge clk_clk); #1;
    chk("deferred_rst_start", {31'd0, hpi_rst_n}, 0);
    got = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk_clk); #1;
      chip_rst_req = (n == 5);
      if (hpi_rst_n) begin got = 1'b1; break; end
    end
    chip_rst_req = 1'b0;
    chk("deferred_rst_len", got ? n : 0, 16);

    // Asynchronous reset in the middle of a read strobe abandons it.
    wait_idle();
    drive('{1'b1, 1'b0, HPI_DATA, 16'h0000, 16'h7777, 11});
    repeat (5) begin @(posedge clk_clk); #1; end
    chk("async_in_strobe", {31'd0, hpi_r_n}, 0);
    #2 reset_reset_n = 1'b0;
    #1;
    chk("async_strobes", {29'd0, hpi_cs_n, hpi_r_n, hpi_w_n}, 7);
    chk("async_hpi_rst_n", {31'd0, hpi_rst_n}, 0);
    chk("async_no_ack", {30'd0, m0_ack, m1_ack}, 0);
    sb.delete();
    m1_req = 1'b0;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    repeat (2) @(negedge clk_clk);
    chk("async_rdata", {m0_rdata, m1_rdata}, 0);
    reset_reset_n = 1'b1;
    powerup_check();

    do_txn('{1'b1, 1'b0, HPI_STATUS, 16'h0000, 16'h0F0F, 11}, 0);
    repeat (3) @(posedge clk_clk);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hpi_access_sequencer.md
Name: hpi_access_sequencer

Overview:
Owns the CY7C67200 OTG host-port interface (HPI) bus. Shares it between two requesters: port 0 is the Nios-side software bridge and port 1 is the hardware keycode poller. It converts each granted request into a timed HPI read or write strobe sequence. It also generates the chip reset pulse, both automatically after system reset and on demand. It sits between the nios_system HPI conduits / poller logic and the board-level OTG pins.

Parameters:
SETUP_CYC, 2, cycles cs_n low with addr/data stable before strobe (>=1)
STROBE_CYC, 6, cycles r_n or w_n held low (>=1)
HOLD_CYC, 2, cycles cs_n low after strobe release (>=1)
RESET_CYC, 16, cycles hpi_rst_n held low per chip reset (>=1)
CNT_W, 8, width of the shared phase counter; every *_CYC must be <= 2**CNT_W-1

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
m0_req  in  1  port 0 request, level; held with fields stable until m0_ack
m0_we  in  1  1=write, 0=read
m0_addr  in  2  HPI register select
m0_wdata  in  16  write data
m0_ack  out  1  one-cycle completion pulse
m0_rdata  out  16  read data, valid with m0_ack, held until next port-0 read completes
m1_req/m1_we/m1_addr/m1_wdata/m1_ack/m1_rdata  same as port 0, for port 1
chip_rst_req  in  1  single-cycle pulse requesting an OTG chip reset
hpi_addr  out  2  HPI address
hpi_cs_n  out  1  chip select, active low
hpi_r_n  out  1  read strobe, active low
hpi_w_n  out  1  write strobe, active low
hpi_rst_n  out  1  chip reset, active low
hpi_data_out  out  16  write data to pad
hpi_data_oe  out  1  pad output enable
hpi_data_in  in  16  read data from pad
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- FSM states: IDLE, SETUP, STROBE, HOLD, CHIPRST. A single down-counter loads on each state entry.
- Reset values: state=CHIPRST, counter=RESET_CYC, hpi_rst_n=0, cs_n=r_n=w_n=1, hpi_addr=0, data_out=0, oe=0, acks=0, rdata=0, busy=1, last_grant=1, rst_pending=0.
- Power-up: after reset releases, the chip reset pulse runs automatically.
- CHIPRST:
  - hpi_rst_n=0; cs_n, r_n and w_n are 1.
  - After RESET_CYC cycles: go to IDLE and set hpi_rst_n=1.
- IDLE, in priority order:
  - rst_pending or chip_rst_req: go to CHIPRST and clear rst_pending.
  - Otherwise arbitrate among eligible requests. A port is eligible if its req=1 and its ack is not high this cycle.
  - If both ports are eligible, grant the port not in last_grant (round-robin). If one is eligible, grant it.
  - On grant: latch we/addr/wdata, update last_grant, go to SETUP.
- SETUP (SETUP_CYC cycles):
  - cs_n=0 and hpi_addr=latched value.
  - Write: oe=1 and data_out=wdata.
- STROBE (STROBE_CYC cycles):
  - Read: r_n=0.
  - Write: w_n=0.
  - Read data: hpi_data_in is captured into an internal register on the last STROBE cycle.
- HOLD (HOLD_CYC cycles):
  - r_n=w_n=1.
  - cs_n=0; addr, data_out and oe are held.
- HOLD exit:
  - Go to IDLE and drive cs_n=1, oe=0.
  - The granted port's ack=1 for exactly one cycle (the first IDLE cycle).
  - On reads, that port's rdata is updated in the same cycle.
- Latency: ack rises 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles after the IDLE edge that granted. That is 11 cycles at the defaults.
- Minimum idle gap: cs_n is high for at least one cycle between transactions.
- chip_rst_req during SETUP, STROBE or HOLD:
  - Sets rst_pending.
  - The transaction completes normally with its ack, then CHIPRST is entered.
- chip_rst_req during CHIPRST: ignored; the counter is not reloaded.
- Mid-operation reset: assertion of reset_reset_n asynchronously forces the reset values. The transaction is abandoned and no ack is issued.
- Write stability: hpi_data_out never changes while cs_n=0.

Decomposition:
- Package hpi_pkg contains:
  - the state enum;
  - HPI register constants HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDR=2'd2, HPI_STATUS=2'd3.
- Sub-module hpi_rr_arbiter: 2-way round-robin with req[1:0], last_grant and enable inputs, and grant[1:0] one-hot output.

Test Plan:
- Power-up: release reset_reset_n → hpi_rst_n=0 for 16 cycles, then 1. busy falls in the same cycle. cs_n stays 1 throughout.
- Single write: m0 writes addr=2, wdata=16'h1234. Expect:
  - cs_n low for 10 cycles;
  - w_n low for exactly 6 cycles, starting 2 cycles after cs_n falls;
  - data_out=16'h1234 with oe=1 for the whole cs_n window;
  - m0_ack one pulse 11 cycles after the grant edge.
- Single read: m1 reads addr=3, with the bench driving hpi_data_in=16'hBEEF during STROBE → m1_rdata=16'hBEEF with m1_ack; r_n low 6 cycles; oe=0 throughout.
- Contention: m0 and m1 both hold req continuously → grants alternate m0, m1, m0, m1. Each ack is followed by at least one cs_n-high cycle, and no port is granted twice in a row.
- Reset during a transaction:
  - chip_rst_req pulses in the 3rd STROBE cycle → that transaction completes with its ack, then hpi_rst_n=0 for 16 cycles.
  - A second chip_rst_req during CHIPRST does not extend the pulse.
- Async reset mid-STROBE: reset_reset_n dropped → cs_n, r_n and w_n go to 1 and hpi_rst_n to 0 immediately, with no ack pulse. After release, the power-up sequence repeats.
